// File: rtl/cw305_reg_bank_mc.sv
// Multi-channel operand/result register bank for the CW305 Kyber target.
// Byte-wide host access via the register front-end, word-wide core access, go/busy/done control.
module cw305_reg_bank_mc #(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 8,
  parameter int pCHANNELS     = 2,
  parameter int pWORDS        = 8,
  parameter int pCNT_WIDTH    = 32,
  localparam int AW = (pWORDS > 1) ? $clog2(pWORDS) : 1
) (
  input  logic                     crypto_clk,
  input  logic                     reset_i,
  input  logic [pADDR_WIDTH-1:0]   reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               write_data,
  input  logic                     reg_write,
  input  logic                     reg_read,
  input  logic                     reg_addrvalid,
  output logic [7:0]               read_data,
  input  logic [3:0]               I_k_chan,
  input  logic [AW-1:0]            I_k_addr,
  output logic [31:0]              O_k_word,
  input  logic                     I_r_wren,
  input  logic [3:0]               I_r_chan,
  input  logic [AW-1:0]            I_r_addr,
  input  logic [31:0]              I_r_word,
  input  logic                     I_busy,
  input  logic                     I_done,
  output logic                     O_start,
  output logic                     O_busy,
  output logic [1:0]               dbg_state
);

  localparam int CW        = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1;
  localparam int CNT_BYTES = pCNT_WIDTH / 8;
  localparam logic [pBYTECNT_SIZE:0] NBYTES_L    = (pBYTECNT_SIZE+1)'(4 * pWORDS);
  localparam logic [pBYTECNT_SIZE:0] CNT_BYTES_L = (pBYTECNT_SIZE+1)'(CNT_BYTES);
  localparam logic [4:0] NCH5 = 5'(pCHANNELS);
  localparam logic [7:0] NCH8 = 8'(pCHANNELS);

  localparam logic [pADDR_WIDTH-1:0] A_GO      = pADDR_WIDTH'(0);
  localparam logic [pADDR_WIDTH-1:0] A_STATUS  = pADDR_WIDTH'(1);
  localparam logic [pADDR_WIDTH-1:0] A_CHAN    = pADDR_WIDTH'(2);
  localparam logic [pADDR_WIDTH-1:0] A_CYCLES  = pADDR_WIDTH'(3);
  localparam logic [pADDR_WIDTH-1:0] A_TIMEOUT = pADDR_WIDTH'(4);
  localparam logic [pADDR_WIDTH-1:0] A_OPERAND = pADDR_WIDTH'(5);
  localparam logic [pADDR_WIDTH-1:0] A_RESULT  = pADDR_WIDTH'(6);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             operand_mem [pCHANNELS][pWORDS];
  logic [31:0]             result_mem  [pCHANNELS][pWORDS];
  logic [3:0]              chan_sel_q;
  logic [pCNT_WIDTH-1:0]   cycles_q, timeout_q;
  logic                    done_q, tmo_q, err_go_q, err_lock_q;
  logic                    done_in_q, start_q;
  logic                    go_accept, set_done, set_tmo, set_err_go, set_err_lock;
  logic                    done_rise, timeout_hit;
  logic [7:0]              rd_byte;

  // A host access is a single-cycle strobe (reg_write or reg_read) qualified by
  // reg_addrvalid; there is no back-pressure, every qualified strobe is consumed.
  logic host_wr, host_rd;
  assign host_wr = reg_addrvalid & reg_write;
  assign host_rd = reg_addrvalid & reg_read;

  logic byte0, wr_go, wr_status, wr_chan, wr_timeout, wr_operand;
  assign byte0      = (reg_bytecnt == '0);
  assign wr_go      = host_wr && reg_address == A_GO && byte0;
  assign wr_status  = host_wr && reg_address == A_STATUS && byte0;
  assign wr_chan    = host_wr && reg_address == A_CHAN && byte0;
  assign wr_timeout = host_wr && reg_address == A_TIMEOUT;
  assign wr_operand = host_wr && reg_address == A_OPERAND;

  logic                     buf_byte_ok;
  logic [pBYTECNT_SIZE-1:0] word_sel_full;
  logic [AW-1:0]            buf_word;
  logic [1:0]               buf_lane;
  logic [CW-1:0]            host_chan;
  assign buf_byte_ok   = {1'b0, reg_bytecnt} < NBYTES_L;
  assign word_sel_full = reg_bytecnt >> 2;
  assign buf_word      = word_sel_full[AW-1:0];
  assign buf_lane      = reg_bytecnt[1:0];
  assign host_chan     = chan_sel_q[CW-1:0];

  // Core-side index checks are done on zero-extended copies so they stay
  // meaningful when pWORDS is not a power of two.
  logic [31:0] k_addr_ext, r_addr_ext;
  logic        k_ok, r_ok;
  assign k_addr_ext = 32'(I_k_addr);
  assign r_addr_ext = 32'(I_r_addr);
  assign k_ok = ({1'b0, I_k_chan} < NCH5) && (k_addr_ext < 32'(pWORDS));
  assign r_ok = ({1'b0, I_r_chan} < NCH5) && (r_addr_ext < 32'(pWORDS));

  assign O_k_word  = k_ok ? operand_mem[I_k_chan[CW-1:0]][I_k_addr] : 32'h0;
  assign O_start   = start_q;
  assign O_busy    = (state_q == ST_BUSY);
  assign dbg_state = state_q;

  assign done_rise   = I_done & ~done_in_q;
  assign timeout_hit = (timeout_q != '0) && (cycles_q == timeout_q);

  always_comb begin
    state_d      = state_q;
    go_accept    = 1'b0;
    set_done     = 1'b0;
    set_tmo      = 1'b0;
    set_err_go   = 1'b0;
    set_err_lock = 1'b0;
    case (state_q)
      ST_BUSY: begin
        set_err_go   = wr_go;
        set_err_lock = wr_operand;
        // done takes precedence over a coincident timeout
        if (done_rise) begin
          state_d  = ST_DONE;
          set_done = 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          set_tmo = 1'b1;
        end
      end
      default: begin
        if (wr_go) begin
          go_accept = 1'b1;
          state_d   = ST_BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      done_in_q  <= 1'b0;
      cycles_q   <= '0;
      timeout_q  <= '0;
      chan_sel_q <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      err_go_q   <= 1'b0;
      err_lock_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= go_accept;
      done_in_q <= I_done;
      if (go_accept)
        cycles_q <= '0;
      else if (state_q == ST_BUSY && cycles_q != '1)
        cycles_q <= cycles_q + 1'b1;
      // sticky bits: a set in the same cycle beats a W1C clear
      done_q     <= set_done | (done_q & ~(wr_status & write_data[1]) & ~go_accept);
      tmo_q      <= set_tmo | (tmo_q & ~(wr_status & write_data[2]) & ~go_accept);
      err_go_q   <= set_err_go | (err_go_q & ~(wr_status & write_data[3]));
      err_lock_q <= set_err_lock | (err_lock_q & ~(wr_status & write_data[4]));
      if (wr_chan)
        chan_sel_q <= (write_data >= NCH8) ? 4'(pCHANNELS - 1) : write_data[3:0];
      if (wr_timeout) begin
        for (int b = 0; b < CNT_BYTES; b++)
          if (reg_bytecnt == pBYTECNT_SIZE'(b)) timeout_q[b*8 +: 8] <= write_data;
      end
    end
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      for (int c = 0; c < pCHANNELS; c++)
        for (int w = 0; w < pWORDS; w++) begin
          operand_mem[c][w] <= '0;
          result_mem[c][w]  <= '0;
        end
    end else begin
      if (wr_operand && state_q != ST_BUSY && buf_byte_ok)
        operand_mem[host_chan][buf_word][{buf_lane, 3'b000} +: 8] <= write_data;
      if (I_r_wren && r_ok)
        result_mem[I_r_chan[CW-1:0]][I_r_addr] <= I_r_word;
    end
  end

  always_comb begin
    logic [pCNT_WIDTH-1:0] cnt_shift;
    cnt_shift = '0;
    rd_byte   = 8'h00;
    case (reg_address)
      A_STATUS:
        if (byte0) rd_byte = {2'b00, I_busy, err_lock_q, err_go_q, tmo_q, done_q, O_busy};
      A_CHAN:
        if (byte0) rd_byte = {4'h0, chan_sel_q};
      A_CYCLES: begin
        cnt_shift = cycles_q >> {reg_bytecnt, 3'b000};
        if ({1'b0, reg_bytecnt} < CNT_BYTES_L) rd_byte = cnt_shift[7:0];
      end
      A_TIMEOUT: begin
        cnt_shift = timeout_q >> {reg_bytecnt, 3'b000};
        if ({1'b0, reg_bytecnt} < CNT_BYTES_L) rd_byte = cnt_shift[7:0];
      end
      A_OPERAND:
        if (buf_byte_ok) rd_byte = 8'(operand_mem[host_chan][buf_word] >> {buf_lane, 3'b000});
      A_RESULT:
        if (buf_byte_ok) rd_byte = 8'(result_mem[host_chan][buf_word] >> {buf_lane, 3'b000});
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) read_data <= 8'h00;
    else         read_data <= host_rd ? rd_byte : 8'h00;
  end

endmodule

// File: tb/tb_cw305_reg_bank_mc.sv
// Bench for cw305_reg_bank_mc: directed scenarios plus random traffic,
// checked against a byte-array reference model of the register bank.
module tb_cw305_reg_bank_mc;

  localparam int NCH = 2;

  logic        crypto_clk = 1'b0;
  logic        reset_i;
  logic [7:0]  reg_address, reg_bytecnt, write_data, read_data;
  logic        reg_write, reg_read, reg_addrvalid;
  logic [3:0]  I_k_chan, I_r_chan;
  logic [2:0]  I_k_addr, I_r_addr;
  logic [31:0] O_k_word, I_r_word;
  logic        I_r_wren, I_busy, I_done, O_start, O_busy;
  logic [1:0]  dbg_state;

  cw305_reg_bank_mc dut (
    .crypto_clk(crypto_clk), .reset_i(reset_i),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .write_data(write_data),
    .reg_write(reg_write), .reg_read(reg_read), .reg_addrvalid(reg_addrvalid),
    .read_data(read_data),
    .I_k_chan(I_k_chan), .I_k_addr(I_k_addr), .O_k_word(O_k_word),
    .I_r_wren(I_r_wren), .I_r_chan(I_r_chan), .I_r_addr(I_r_addr), .I_r_word(I_r_word),
    .I_busy(I_busy), .I_done(I_done), .O_start(O_start), .O_busy(O_busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 crypto_clk = ~crypto_clk;

  // reference model
  logic [7:0]  m_op  [NCH][32];
  logic [7:0]  m_res [NCH][32];
  logic [3:0]  m_chan;
  logic [31:0] m_timeout, m_cycles;
  bit          m_running, m_done, m_tmo, m_errgo, m_errlock, m_done_prev, m_start;
  logic [7:0]  exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < 32; b++) begin
        m_op[c][b]  = 8'h00;
        m_res[c][b] = 8'h00;
      end
    m_chan = 0; m_timeout = 0; m_cycles = 0;
    m_running = 0; m_done = 0; m_tmo = 0; m_errgo = 0; m_errlock = 0;
    m_done_prev = 0; m_start = 0;
  endtask

  function automatic logic [7:0] model_read(input int a, input int bc);
    logic [31:0] t;
    case (a)
      1: return (bc == 0) ? {2'b00, I_busy, m_errlock, m_errgo, m_tmo, m_done, m_running} : 8'h00;
      2: return (bc == 0) ? {4'h0, m_chan} : 8'h00;
      3: begin t = m_cycles >> (8 * bc);  return (bc < 4) ? t[7:0] : 8'h00; end
      4: begin t = m_timeout >> (8 * bc); return (bc < 4) ? t[7:0] : 8'h00; end
      5: return (bc < 32) ? m_op[m_chan][bc] : 8'h00;
      6: return (bc < 32) ? m_res[m_chan][bc] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] exp_k_word();
    int base;
    if (int'(I_k_chan) >= NCH) return 32'h0;
    base = 4 * int'(I_k_addr);
    return {m_op[I_k_chan][base+3], m_op[I_k_chan][base+2], m_op[I_k_chan][base+1], m_op[I_k_chan][base]};
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_clock();
    int  a, bc, base;
    bit  wr, rd, go, was_running;
    a  = int'(reg_address);
    bc = int'(reg_bytecnt);
    wr = reg_addrvalid && reg_write;
    rd = reg_addrvalid && reg_read;
    if (reset_i) begin
      model_reset();
      exp_q.push_back(8'h00);
      return;
    end
    exp_q.push_back(rd ? model_read(a, bc) : 8'h00);
    was_running = m_running;
    go = wr && a == 0 && bc == 0;
    m_start = 0;
    if (wr && a == 1 && bc == 0) begin
      if (write_data[1]) m_done = 0;
      if (write_data[2]) m_tmo = 0;
      if (write_data[3]) m_errgo = 0;
      if (write_data[4]) m_errlock = 0;
    end
    if (was_running) begin
      if (go) m_errgo = 1;
      if (wr && a == 5) m_errlock = 1;
      if (I_done && !m_done_prev) begin
        m_running = 0; m_done = 1;
      end else if (m_timeout != 0 && m_cycles == m_timeout) begin
        m_running = 0; m_tmo = 1;
      end
      if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    end else if (go) begin
      m_start = 1; m_running = 1; m_cycles = 0; m_done = 0; m_tmo = 0;
    end
    if (wr && a == 2 && bc == 0) m_chan = (int'(write_data) >= NCH) ? 4'(NCH - 1) : write_data[3:0];
    if (wr && a == 4 && bc < 4) m_timeout[8*bc +: 8] = write_data;
    if (wr && a == 5 && !was_running && bc < 32) m_op[m_chan][bc] = write_data;
    if (I_r_wren && int'(I_r_chan) < NCH) begin
      base = 4 * int'(I_r_addr);
      for (int k = 0; k < 4; k++) m_res[I_r_chan][base+k] = I_r_word[8*k +: 8];
    end
    m_done_prev = I_done;
  endtask

  // one clock: model steps, DUT steps, outputs compared on the falling edge
  task automatic tick();
    logic [7:0] e;
    model_clock();
    @(negedge crypto_clk);
    e = exp_q.pop_front();
    if (O_start === 1'b1) start_cnt++;
    check("read_data", 32'(read_data), 32'(e));
    check("O_start", 32'(O_start), 32'(m_start));
    check("O_busy", 32'(O_busy), 32'(m_running));
    check("O_k_word", O_k_word, exp_k_word());
  endtask

  // driver tasks
  task automatic host_write(input logic [7:0] a, input logic [7:0] bc, input logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; write_data = d;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    tick();
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] bc, output logic [7:0] d);
    reg_address = a; reg_bytecnt = bc;
    reg_read = 1'b1; reg_addrvalid = 1'b1;
    tick();
    d = read_data;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic host_read32(input logic [7:0] a, output logic [31:0] w);
    logic [7:0] d;
    for (int b = 0; b < 4; b++) begin
      host_read(a, 8'(b), d);
      w[8*b +: 8] = d;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    tick();
  endtask

  logic [7:0]  rb;
  logic [31:0] rw;

  initial begin
    reset_i = 1'b1;
    reg_address = 0; reg_bytecnt = 0; write_data = 0;
    reg_write = 0; reg_read = 0; reg_addrvalid = 0;
    I_k_chan = 0; I_k_addr = 0; I_r_wren = 0; I_r_chan = 0; I_r_addr = 0; I_r_word = 0;
    I_busy = 0; I_done = 0;
    model_reset();
    @(negedge crypto_clk);
    do_reset();

    // reset state of every register
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 4; b++) begin
        host_read(8'(a), 8'(b), rb);
        check("reset_reg", 32'(rb), 32'h0);
      end
    check("reset_start", 32'(O_start), 32'h0);
    check("reset_busy", 32'(O_busy), 32'h0);

    // operand bytes land little-endian in the selected channel
    host_write(8'h02, 8'h00, 8'h01);
    host_write(8'h05, 8'h00, 8'h11);
    host_write(8'h05, 8'h01, 8'h22);
    host_write(8'h05, 8'h02, 8'h33);
    host_write(8'h05, 8'h03, 8'h44);
    I_k_chan = 4'd1; I_k_addr = 3'd0;
    tick();
    check("k_word_ch1", O_k_word, 32'h4433_2211);
    I_k_chan = 4'd0;
    tick();
    check("k_word_ch0", O_k_word, 32'h0);

    // GO, done after 10 idle cycles
    start_cnt = 0;
    host_write(8'h00, 8'h00, 8'h01);
    repeat (10) tick();
    I_done = 1'b1; tick(); I_done = 1'b0; tick();
    check("start_once", 32'(start_cnt), 32'd1);
    host_read(8'h01, 8'h00, rb);
    check("status_done", 32'(rb), 32'h02);
    host_read32(8'h03, rw);
    check("cycles_done", rw, 32'd11);
    host_write(8'h01, 8'h00, 8'h02);
    host_read(8'h01, 8'h00, rb);
    check("status_w1c", 32'(rb), 32'h00);

    // timeout
    host_write(8'h04, 8'h00, 8'h05);
    host_write(8'h00, 8'h00, 8'h01);
    repeat (10) tick();
    host_read(8'h01, 8'h00, rb);
    check("status_tmo", 32'(rb), 32'h04);
    check("tmo_idle", 32'(O_busy), 32'h0);

    // GO while busy and operand lock
    host_write(8'h04, 8'h00, 8'h00);
    start_cnt = 0;
    host_write(8'h00, 8'h00, 8'h01);
    tick();
    host_write(8'h00, 8'h00, 8'h01);
    host_write(8'h05, 8'h00, 8'h99);
    tick();
    check("second_go_start", 32'(start_cnt), 32'd1);
    host_read(8'h01, 8'h00, rb);
    check("status_errs", 32'(rb), 32'h19);
    host_read(8'h05, 8'h00, rb);
    check("operand_locked", 32'(rb), 32'h11);
    I_done = 1'b1; tick(); I_done = 1'b0;
    host_write(8'h01, 8'h00, 8'h1E);

    // core result write, out-of-range channel dropped
    I_r_wren = 1'b1; I_r_chan = 4'd1; I_r_addr = 3'd7; I_r_word = 32'hDEAD_BEEF;
    tick();
    I_r_chan = 4'd5; I_r_word = 32'h1234_5678;
    tick();
    I_r_wren = 1'b0;
    host_read(8'h06, 8'd28, rb); check("res_b28", 32'(rb), 32'hEF);
    host_read(8'h06, 8'd29, rb); check("res_b29", 32'(rb), 32'hBE);
    host_read(8'h06, 8'd30, rb); check("res_b30", 32'(rb), 32'hAD);
    host_read(8'h06, 8'd31, rb); check("res_b31", 32'(rb), 32'hDE);
    I_k_chan = 4'd3; tick();
    check("k_word_bad_chan", O_k_word, 32'h0);
    I_k_chan = 4'd0;

    // CHAN_SEL clamp and out-of-range buffer byte
    host_write(8'h02, 8'h00, 8'h07);
    host_read(8'h02, 8'h00, rb);
    check("chan_clamp", 32'(rb), 32'd1);
    host_read(8'h06, 8'd32, rb);
    check("res_oob", 32'(rb), 32'h0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int op;
      reset_i       = ($urandom_range(0, 299) == 0);
      reg_address   = 8'($urandom_range(0, 7));
      reg_bytecnt   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 35));
      write_data    = 8'($urandom_range(0, 255));
      op            = $urandom_range(0, 3);
      reg_write     = (op == 1);
      reg_read      = (op >= 2);
      reg_addrvalid = ($urandom_range(0, 4) != 0);
      I_done        = ($urandom_range(0, 5) == 0);
      I_busy        = 1'($urandom_range(0, 1));
      I_r_wren      = 1'($urandom_range(0, 1));
      I_r_chan      = 4'($urandom_range(0, 3));
      I_r_addr      = 3'($urandom_range(0, 7));
      I_r_word      = $urandom;
      I_k_chan      = 4'($urandom_range(0, 3));
      I_k_addr      = 3'($urandom_range(0, 7));
      tick();
    end
    reset_i = 0; reg_write = 0; reg_read = 0; reg_addrvalid = 0;
    I_done = 0; I_busy = 0; I_r_wren = 0; I_k_chan = 0; I_k_addr = 0;

    // reset in the middle of BUSY
    do_reset();
    host_write(8'h02, 8'h00, 8'h01);
    host_write(8'h05, 8'h00, 8'h5A);
    host_write(8'h00, 8'h00, 8'h01);
    repeat (3) tick();
    check("busy_before_rst", 32'(O_busy), 32'h1);
    start_cnt = 0;
    do_reset();
    tick();
    check("rst_busy", 32'(O_busy), 32'h0);
    check("rst_no_start", 32'(start_cnt), 32'd0);
    host_read(8'h01, 8'h00, rb); check("rst_status", 32'(rb), 32'h0);
    host_read32(8'h03, rw);      check("rst_cycles", rw, 32'h0);
    host_read(8'h02, 8'h00, rb); check("rst_chan", 32'(rb), 32'h0);
    host_write(8'h02, 8'h00, 8'h01);
    host_read(8'h05, 8'h00, rb); check("rst_operand", 32'(rb), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
